// File: rtl/adder381_pkg.sv
// Shared constants and FSM encoding for the 381-bit sequential adder.
package adder381_pkg;

  localparam int WIDTH    = 381;
  localparam int CHUNK    = 32;
  localparam int CHUNK_LG = $clog2(CHUNK);
  localparam int NCHUNK   = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PWIDTH   = NCHUNK * CHUNK;
  localparam int IDXW     = $clog2(NCHUNK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/cla_add_32bit.sv
// 32-bit carry-lookahead adder slice: 4-bit groups with a lookahead chain across groups.
module cla_add_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] p;
  logic [31:0] g;
  logic [32:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [8:0]  grp_c;

  // Bit propagate/generate, group lookahead terms, then per-bit carries inside each group.
  always_comb begin
    p     = a ^ b;
    g     = a & b;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int i = 0; i < 8; i++) begin
      grp_g[i] = g[4*i+3]
               | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];
    end
    grp_c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
    for (int i = 0; i < 8; i++) begin
      c[4*i] = grp_c[i];
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
      end
    end
    c[32] = grp_c[8];
    sum   = p ^ c[31:0];
    cout  = c[32];
  end

endmodule

// File: rtl/adder_381bit_seq_ctrl.sv
// Sequencer that adds two 381-bit operands one 32-bit chunk per clock through a shared CLA slice.
module adder_381bit_seq_ctrl
  import adder381_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [PWIDTH-1:0]    a_q, a_d;
  logic [PWIDTH-1:0]    b_q, b_d;
  logic [PWIDTH-1:0]    sum_q, sum_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [IDXW+CHUNK_LG-1:0] base;
  logic [CHUNK-1:0]         slice_sum;
  logic                     slice_cout;

  assign base = {idx_q, {CHUNK_LG{1'b0}}};

  cla_add_32bit u_slice (
    .a    (a_q[base +: CHUNK]),
    .b    (b_q[base +: CHUNK]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state logic: capture operands, walk chunks LSB-first, hold the result until taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = {{(PWIDTH-WIDTH){1'b0}}, a};
          b_d     = {{(PWIDTH-WIDTH){1'b0}}, b};
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = slice_sum;
        carry_d              = slice_cout;
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          idx_d   = '0;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == HOLD);
  end

  // State, datapath and registered handshake outputs; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Bits above WIDTH hold the final carry; the two padding bits are structurally zero.
  assign sum       = sum_q[WIDTH-1:0];
  assign cout      = |sum_q[PWIDTH-1:WIDTH];
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_381bit_seq_ctrl.sv
// Self-checking bench: directed vector table, stall/reset sequences and random operations.
module tb_adder_381bit_seq_ctrl;

  localparam int W = 381;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int compared;
  int mismatched;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] expSum;
    logic         expCout;
    string        name;
  } vec_t;

  vec_t vecs[8];

  adder_381bit_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records one comparison; wide values printed in hex.
  task automatic checkOutput(input string name, input logic [383:0] act, input logic [383:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one full operation: capture, 12 RUN cycles, optional stall in HOLD, release.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                               input logic [W-1:0] expSum, input logic expCout,
                               input int stallCycles, input bit pokeIn, input string name);
    int  waitCnt;
    int  cycles;
    bit  busyReadyBad;
    bit  holdBad;
    bit  acceptBad;
    logic [W-1:0] heldSum;
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput({name, "_ready_timeout"}, 384'(in_ready), 384'(1));
      return;
    end
    a        = va;
    b        = vb;
    cin      = vcin;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid     = 1'b0;
    cycles       = 0;
    busyReadyBad = 1'b0;
    while (!out_valid && cycles < 40) begin
      if (in_ready) busyReadyBad = 1'b1;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checkOutput({name, "_latency"}, 384'(cycles), 384'(12));
    checkOutput({name, "_busy_in_ready"}, 384'(busyReadyBad), 384'(0));
    checkOutput({name, "_sum"}, 384'(sum), 384'(expSum));
    checkOutput({name, "_cout"}, 384'(cout), 384'(expCout));
    heldSum   = sum;
    holdBad   = 1'b0;
    acceptBad = 1'b0;
    for (int i = 0; i < stallCycles; i++) begin
      if (pokeIn) begin
        in_valid = ~in_valid;
        a        = ~va;
        b        = ~vb;
      end
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || sum !== heldSum || cout !== expCout) holdBad = 1'b1;
      if (in_ready) acceptBad = 1'b1;
    end
    in_valid = 1'b0;
    if (stallCycles > 0) begin
      checkOutput({name, "_hold_stable"}, 384'(holdBad), 384'(0));
      checkOutput({name, "_hold_no_accept"}, 384'(acceptBad), 384'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({name, "_release_valid"}, 384'(out_valid), 384'(0));
    checkOutput({name, "_release_ready"}, 384'(in_ready), 384'(1));
    checkOutput({name, "_release_sum"}, 384'(sum), 384'(expSum));
  endtask

  logic [W-1:0] ones;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic         rc;
  logic [W:0]   ref_res;
  logic [W-1:0] one;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    ones       = {W{1'b1}};
    one        = W'(1);

    vecs[0] = '{one, one, 1'b0, W'(2), 1'b0, "one_plus_one"};
    vecs[1] = '{ones, '0, 1'b1, '0, 1'b1, "full_ripple"};
    vecs[2] = '{ones, ones, 1'b1, ones, 1'b1, "all_ones"};
    vecs[3] = '{W'(3), W'(4), 1'b0, W'(7), 1'b0, "three_four"};
    vecs[4] = '{W'(32'hFFFF_FFFF), one, 1'b0, one << 32, 1'b0, "chunk0_carry"};
    vecs[5] = '{(one << 352) - one, '0, 1'b1, one << 352, 1'b0, "into_last_chunk"};
    vecs[6] = '{one << 380, one << 380, 1'b0, '0, 1'b1, "top_bit_cout"};
    vecs[7] = '{'0, '0, 1'b1, one, 1'b0, "cin_only"};

    #1;
    checkOutput("reset_in_ready", 384'(in_ready), 384'(0));
    checkOutput("reset_out_valid", 384'(out_valid), 384'(0));
    checkOutput("reset_sum", 384'(sum), 384'(0));
    checkOutput("reset_cout", 384'(cout), 384'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].expSum, vecs[i].expCout,
                    i % 3, 1'b0, vecs[i].name);
    end

    $display("[TB] long HOLD stall with in_valid pulses");
    applyStimulus(W'(100), W'(23), 1'b1, W'(124), 1'b0, 20, 1'b1, "stall20");

    $display("[TB] reset in the middle of RUN");
    a        = ones;
    b        = ones;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_out_valid", 384'(out_valid), 384'(0));
    checkOutput("midrun_reset_in_ready", 384'(in_ready), 384'(0));
    checkOutput("midrun_reset_sum", 384'(sum), 384'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("after_reset_in_ready", 384'(in_ready), 384'(1));
    applyStimulus(W'(3), W'(4), 1'b0, W'(7), 1'b0, 0, 1'b0, "after_reset_op");

    $display("[TB] random operations");
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 12; k++) begin
        ra[k*32 +: 29] = 29'($urandom);
        rb[k*32 +: 29] = 29'($urandom);
        if (k < 11) begin
          ra[k*32+29 +: 3] = 3'($urandom);
          rb[k*32+29 +: 3] = 3'($urandom);
        end
      end
      if (n % 50 == 0) ra = ones;
      rc      = 1'($urandom);
      ref_res = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      applyStimulus(ra, rb, rc, ref_res[W-1:0], ref_res[W],
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
